// File: rtl/or_tree_pkg.sv
// rtl/or_tree_pkg.sv - mode codes and elaboration-time sizing helpers for or_tree_pipe
package or_tree_pkg;

    localparam int MODE_BAD  = -1;
    localparam int MODE_OR   = 0;
    localparam int MODE_NOR  = 1;
    localparam int MODE_AND  = 2;
    localparam int MODE_NAND = 3;

    // Smallest L >= 1 with radix**L >= width.
    function automatic int tree_levels(input int width, input int radix);
        int levels;
        int span;
        levels = 1;
        span   = radix;
        while (span < width) begin
            span   = span * radix;
            levels = levels + 1;
        end
        return levels;
    endfunction

    // Number of partial results registered by stage k (n_0 = width).
    function automatic int stage_width(input int width, input int radix, input int k);
        int n;
        n = width;
        for (int i = 0; i <= k; i++) begin
            n = (n + radix - 1) / radix;
        end
        return n;
    endfunction

    function automatic logic identity(input int mode);
        return (mode == MODE_AND) || (mode == MODE_NAND);
    endfunction

endpackage

// File: rtl/or_tree_stage.sv
// rtl/or_tree_stage.sv - one registered RADIX-input reduction level with its valid bit
module or_tree_stage
    import or_tree_pkg::*;
#(
    parameter int N_IN     = 16,
    parameter int RADIX    = 4,
    parameter bit BASE_AND = 1'b0,
    parameter bit INVERT   = 1'b0
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               valid_i,
    input  logic [N_IN-1:0]                    data_i,
    output logic                               valid_o,
    output logic [(N_IN+RADIX-1)/RADIX-1:0]    data_o
);

    localparam int N_OUT = (N_IN + RADIX - 1) / RADIX;
    localparam int N_PAD = N_OUT * RADIX;

    logic [N_PAD-1:0] padded;
    logic [N_OUT-1:0] data_d;
    logic [N_OUT-1:0] data_q;
    logic             valid_q;

    // Unused leaves of the last group take the identity of the base operation.
    always_comb begin
        padded             = {N_PAD{BASE_AND}};
        padded[N_IN-1:0]   = data_i;
    end

    always_comb begin
        data_d = '0;
        for (int g = 0; g < N_OUT; g++) begin
            if (BASE_AND) begin
                data_d[g] = (&padded[g*RADIX +: RADIX]) ^ INVERT;
            end else begin
                data_d[g] = (|padded[g*RADIX +: RADIX]) ^ INVERT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_i;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/or_tree_pipe.sv
// rtl/or_tree_pipe.sv - pipelined wide OR/NOR/AND/NAND gate with sticky hit flag and saturating hit counter
module or_tree_pipe
    import or_tree_pkg::*;
#(
    parameter int    WIDTH = 16,
    parameter int    RADIX = 4,
    parameter string MODE  = "OR",
    parameter int    CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] x,
    input  logic             clr,
    output logic             out_valid,
    output logic             y,
    output logic             sticky_y,
    output logic [CNT_W-1:0] hit_cnt
);

    localparam int MODE_SEL = (MODE == "OR")   ? MODE_OR   :
                              (MODE == "NOR")  ? MODE_NOR  :
                              (MODE == "AND")  ? MODE_AND  :
                              (MODE == "NAND") ? MODE_NAND : MODE_BAD;
    localparam int LEVELS   = tree_levels(WIDTH, RADIX);
    localparam bit BASE_AND = identity(MODE_SEL);
    localparam bit INVERT   = (MODE_SEL == MODE_NOR) || (MODE_SEL == MODE_NAND);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    if (MODE_SEL == MODE_BAD) begin : g_bad_mode
        $error("or_tree_pipe: MODE must be OR, NOR, AND or NAND");
    end
    if (WIDTH < 2) begin : g_bad_width
        $error("or_tree_pipe: WIDTH must be at least 2");
    end
    if (RADIX < 2 || RADIX > 8) begin : g_bad_radix
        $error("or_tree_pipe: RADIX must be in 2..8");
    end

    for (genvar k = 0; k < LEVELS; k++) begin : g_stage
        localparam int N_IN  = (k == 0) ? WIDTH : stage_width(WIDTH, RADIX, k - 1);
        localparam int N_OUT = stage_width(WIDTH, RADIX, k);

        logic [N_IN-1:0]  d_in;
        logic             v_in;
        logic [N_OUT-1:0] d_out;
        logic             v_out;

        if (k == 0) begin : g_first
            assign d_in = x;
            assign v_in = in_valid;
        end else begin : g_next
            assign d_in = g_stage[k-1].d_out;
            assign v_in = g_stage[k-1].v_out;
        end

        // Inversion lives only in the final level so the tree itself stays a pure OR/AND.
        or_tree_stage #(
            .N_IN     (N_IN),
            .RADIX    (RADIX),
            .BASE_AND (BASE_AND),
            .INVERT   (INVERT && (k == LEVELS - 1))
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .valid_i (v_in),
            .data_i  (d_in),
            .valid_o (v_out),
            .data_o  (d_out)
        );
    end

    assign out_valid = g_stage[LEVELS-1].v_out;
    assign y         = g_stage[LEVELS-1].d_out[0];

    logic             hit;
    logic             sticky_d, sticky_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    assign hit = out_valid && y;

    // A hit in the same cycle as clr is counted on top of the clear.
    always_comb begin
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        if (hit) begin
            sticky_d = 1'b1;
            if (clr) begin
                cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (clr) begin
            sticky_d = 1'b0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    assign sticky_y = sticky_q;
    assign hit_cnt  = cnt_q;

endmodule

// File: tb/tb_or_tree_pipe.sv
// tb/tb_or_tree_pipe.sv - directed self-checking bench for or_tree_pipe
module tb_or_tree_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // OR, 16 bits, radix 4: two levels
    logic        v16, clr16, ov16, y16, st16;
    logic [15:0] x16;
    logic [7:0]  cnt16;
    // NAND, 17 bits, radix 4: three levels with partial groups
    logic        v17, clr17, ov17, y17, st17;
    logic [16:0] x17;
    logic [7:0]  cnt17;
    // OR, 16 bits, radix 2: four levels, 3-bit counter
    logic        vs, clrs, ovs, ys, sts;
    logic [15:0] xs;
    logic [2:0]  cnts;
    // OR, 3 bits, radix 4: one level
    logic        v3, clr3, ov3, y3, st3;
    logic [2:0]  x3;
    logic [7:0]  cnt3;

    or_tree_pipe #(.WIDTH(16), .RADIX(4), .MODE("OR"), .CNT_W(8)) u_or16 (
        .clk(clk), .rst_n(rst_n), .in_valid(v16), .x(x16), .clr(clr16),
        .out_valid(ov16), .y(y16), .sticky_y(st16), .hit_cnt(cnt16));

    or_tree_pipe #(.WIDTH(17), .RADIX(4), .MODE("NAND"), .CNT_W(8)) u_nand17 (
        .clk(clk), .rst_n(rst_n), .in_valid(v17), .x(x17), .clr(clr17),
        .out_valid(ov17), .y(y17), .sticky_y(st17), .hit_cnt(cnt17));

    or_tree_pipe #(.WIDTH(16), .RADIX(2), .MODE("OR"), .CNT_W(3)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(vs), .x(xs), .clr(clrs),
        .out_valid(ovs), .y(ys), .sticky_y(sts), .hit_cnt(cnts));

    or_tree_pipe #(.WIDTH(3), .RADIX(4), .MODE("OR"), .CNT_W(8)) u_or3 (
        .clk(clk), .rst_n(rst_n), .in_valid(v3), .x(x3), .clr(clr3),
        .out_valid(ov3), .y(y3), .sticky_y(st3), .hit_cnt(cnt3));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] s_vec [4];
    logic        s_pat [4];

    initial begin
        s_vec = '{16'h0010, 16'h0000, 16'hFFFF, 16'h8000};
        s_pat = '{1'b1, 1'b1, 1'b0, 1'b1};

        rst_n = 1'b0;
        v16 = 0; clr16 = 0; x16 = '0;
        v17 = 0; clr17 = 0; x17 = '0;
        vs  = 0; clrs  = 0; xs  = '0;
        v3  = 0; clr3  = 0; x3  = '0;
        tick();
        tick();
        rst_n = 1'b1;

        check("rst_ov16",  ov16,  0);
        check("rst_y16",   y16,   0);
        check("rst_st16",  st16,  0);
        check("rst_cnt16", cnt16, 0);
        check("rst_ov17",  ov17,  0);
        check("rst_y17",   y17,   0);
        check("rst_ovs",   ovs,   0);
        check("rst_cnts",  cnts,  0);
        check("rst_ov3",   ov3,   0);

        // OR16: miss then hit, latency 2
        x16 = 16'h0000; v16 = 1;
        tick();
        check("or16_lat_ov0", ov16, 0);
        x16 = 16'h0100;
        tick();
        check("or16_ov_a", ov16, 1);
        check("or16_y_a",  y16,  0);
        v16 = 0; x16 = '0;
        tick();
        check("or16_ov_b", ov16, 1);
        check("or16_y_b",  y16,  1);
        check("or16_st_b", st16, 0);
        tick();
        check("or16_ov_c",  ov16,  0);
        check("or16_st_c",  st16,  1);
        check("or16_cnt_c", cnt16, 1);

        // NAND17: pad bit must be 1 for the partial groups
        x17 = 17'h1FFFF; v17 = 1;
        tick();
        check("nand_ov_e0", ov17, 0);
        x17 = 17'h0FFFF;
        tick();
        check("nand_ov_e1", ov17, 0);
        v17 = 0; x17 = '0;
        tick();
        check("nand_ov_a", ov17, 1);
        check("nand_y_a",  y17,  0);
        tick();
        check("nand_ov_b", ov17, 1);
        check("nand_y_b",  y17,  1);
        tick();
        check("nand_ov_c", ov17, 0);

        // OR16 throughput with a gap
        for (int i = 0; i < 6; i++) begin
            v16 = (i < 4) ? s_pat[i] : 1'b0;
            x16 = (i < 4) ? s_vec[i] : 16'h0000;
            tick();
            if (i >= 1) begin
                logic exp_ov;
                exp_ov = (i - 1 < 4) ? s_pat[i-1] : 1'b0;
                check($sformatf("strm_ov_%0d", i), ov16, exp_ov);
                if (exp_ov)
                    check($sformatf("strm_y_%0d", i), y16, (s_vec[i-1] != 16'h0000));
            end
        end
        tick();
        check("strm_cnt", cnt16, 3);

        // OR3: exhaustive, single level
        for (int i = 0; i < 8; i++) begin
            x3 = 3'(i); v3 = 1;
            tick();
            check($sformatf("or3_ov_%0d", i), ov3, 1);
            check($sformatf("or3_y_%0d", i),  y3,  (i != 0));
        end
        v3 = 0;
        tick();
        check("or3_ov_end", ov3, 0);

        // Saturation: 10 hits into a 3-bit counter, latency 4
        for (int i = 0; i < 15; i++) begin
            int e;
            vs = (i < 10);
            xs = 16'h0001 << (i % 16);
            tick();
            e = i - 3;
            if (e < 0) e = 0;
            if (e > 7) e = 7;
            check($sformatf("sat_cnt_%0d", i), cnts, e);
        end
        check("sat_st", sts, 1);

        // clr while a hit is in flight, then clr together with the hit
        xs = 16'h8000; vs = 1;
        tick();
        vs = 0; clrs = 1;
        tick();
        clrs = 0;
        check("clr_cnt", cnts, 0);
        check("clr_st",  sts,  0);
        tick();
        check("clr_ov_wait", ovs, 0);
        tick();
        check("clr_ov_hit", ovs, 1);
        check("clr_y_hit",  ys,  1);
        clrs = 1;
        tick();
        clrs = 0;
        check("clrhit_cnt", cnts, 1);
        check("clrhit_st",  sts,  1);

        // Reset with three operands in flight
        xs = 16'hFFFF; vs = 1;
        tick();
        tick();
        tick();
        vs = 0; rst_n = 0;
        tick();
        rst_n = 1;
        check("mrst_ov",  ovs,  0);
        check("mrst_y",   ys,   0);
        check("mrst_st",  sts,  0);
        check("mrst_cnt", cnts, 0);
        check("mrst_ov16", ov16, 0);
        for (int j = 0; j < 4; j++) begin
            tick();
            check($sformatf("mrst_drain_%0d", j), ovs, 0);
        end
        xs = 16'h0002; vs = 1;
        for (int j = 0; j < 4; j++) begin
            tick();
            if (j == 0) vs = 0;
            check($sformatf("post_ov_%0d", j), ovs, (j == 3));
            if (j == 3) check("post_y", ys, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
